traffic_tick_ext_gen: RTL

//  Upstream front-end for the intersection controller: generates its 1-clk 'tick' strobe and
//  its 'extension' request. Vehicle-detector input is synchronised/debounced; extensions are

---
 rtl/traffic_pkg.sv | 12 +
 rtl/traffic_tick_ext_gen_if.sv | 28 ++
 rtl/sensor_debounce.sv | 38 +++
 rtl/traffic_tick_ext_gen.sv | 123 ++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and widths for the traffic tick/extension front-end.
// Optional statistics counter is enabled by defining TRAFFIC_EXT_STATS_EN.
package traffic_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int EXT_CNT_W = 4;
  localparam int DENIED_W  = 8;
endpackage

// File: rtl/traffic_tick_ext_gen_if.sv
// Signal bundle between the tick/extension generator and its environment.
// TRAFFIC_EXT_STATS_EN adds the ext_denied counter to the bundle.
interface traffic_tick_ext_gen_if;
  import traffic_pkg::*;

  // No valid/ready here: tick and extension are single-cycle strobes with no
  // back-pressure; extension is only ever high in a cycle where tick is high.
  logic                 sensor_raw;
  logic                 ns_green;
  logic                 tick;
  logic                 extension;
  logic [EXT_CNT_W-1:0] ext_count;
  logic                 vehicle_seen;
  state_t               state;
`ifdef TRAFFIC_EXT_STATS_EN
  logic [DENIED_W-1:0]  ext_denied;

  modport master (output sensor_raw, ns_green,
                  input  tick, extension, ext_count, vehicle_seen, state, ext_denied);
  modport slave  (input  sensor_raw, ns_green,
                  output tick, extension, ext_count, vehicle_seen, state, ext_denied);
`else
  modport master (output sensor_raw, ns_green,
                  input  tick, extension, ext_count, vehicle_seen, state);
  modport slave  (input  sensor_raw, ns_green,
                  output tick, extension, ext_count, vehicle_seen, state);
`endif
endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus stability counter for the vehicle detector.
// The debounced level flips after DEB_CYCLES consecutive disagreeing synced samples.
module sensor_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  output logic vehicle_seen
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] stab_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1       <= 1'b0;
      sync_2       <= 1'b0;
      stab_cnt     <= '0;
      vehicle_seen <= 1'b0;
    end else begin
      sync_1 <= sensor_raw;
      sync_2 <= sync_1;
      if (sync_2 != vehicle_seen) begin
        if (stab_cnt == CW'(DEB_CYCLES - 1)) begin
          vehicle_seen <= sync_2;
          stab_cnt     <= '0;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end else begin
        stab_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/traffic_tick_ext_gen.sv
// Tick prescaler, request latch and rate-limited extension grant FSM.
// Defining TRAFFIC_EXT_STATS_EN adds the saturating ext_denied counter.
module traffic_tick_ext_gen
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 16,
  parameter int MAX_EXT    = 3,
  parameter int GAP_TICKS  = 2
) (
  input logic                  clk,
  input logic                  reset,
  traffic_tick_ext_gen_if.slave bus
);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  logic [DIV_W-1:0]     div_cnt;
  logic                 wrap;
  logic                 tick_q;
  logic                 ext_q;
  logic                 vehicle_seen;
  logic                 seen_q;
  logic                 rise;
  logic                 req_pending;
  logic                 grant;
  state_t               state;
  logic [EXT_CNT_W-1:0] ext_count;
  logic [GAP_W-1:0]     gap_cnt;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sensor_raw   (bus.sensor_raw),
    .vehicle_seen (vehicle_seen)
  );

  // Every decision is taken in the wrap cycle so it lands in the same flop stage as tick.
  assign wrap  = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign rise  = vehicle_seen & ~seen_q;
  assign grant = wrap && bus.ns_green && (state == ARMED) && req_pending &&
                 (ext_count < EXT_CNT_W'(MAX_EXT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      tick_q  <= wrap;
    end
  end

  // A fresh edge beats a same-cycle grant so it is served at the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q      <= 1'b0;
      req_pending <= 1'b0;
    end else begin
      seen_q <= vehicle_seen;
      if (!bus.ns_green)  req_pending <= 1'b0;
      else if (rise)      req_pending <= 1'b1;
      else if (grant)     req_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ext_count <= '0;
      gap_cnt   <= '0;
      ext_q     <= 1'b0;
    end else if (!bus.ns_green) begin
      state     <= IDLE;
      ext_count <= '0;
      gap_cnt   <= '0;
      ext_q     <= 1'b0;
    end else begin
      ext_q <= grant;
      if (wrap) begin
        case (state)
          IDLE:  state <= ARMED;
          ARMED: begin
            if (grant) begin
              ext_count <= ext_count + 1'b1;
              if (GAP_TICKS != 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_W'(GAP_TICKS - 1)) state <= ARMED;
            else gap_cnt <= gap_cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef TRAFFIC_EXT_STATS_EN
  logic [DENIED_W-1:0] denied;

  // A request still pending when the phase ends at the cap is a denied extension.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      denied <= '0;
    end else if (!bus.ns_green && req_pending &&
                 (ext_count == EXT_CNT_W'(MAX_EXT)) && (denied != '1)) begin
      denied <= denied + 1'b1;
    end
  end

  assign bus.ext_denied = denied;
`endif

  assign bus.tick         = tick_q;
  assign bus.extension    = ext_q;
  assign bus.ext_count    = ext_count;
  assign bus.vehicle_seen = vehicle_seen;
  assign bus.state        = state;
endmodule
